fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h1000, SHALL be the first fetch address after reset.
REQ-002 Parameter PC_STEP, default 64'd8, SHALL be the sequential PC increment in bytes.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 imem_req  out  1  SHALL request an instruction read, one-cycle pulse.
REQ-006 imem_addr  out  64  SHALL be the read address, valid while imem_req=1.
REQ-007 imem_rvalid  in  1  SHALL indicate that the read response is present.
REQ-008 imem_rdata  in  64  SHALL be the instruction word, valid with imem_rvalid.
REQ-009 imem_err  in  1  SHALL flag the response as a faulting access, qualified by imem_rvalid.
REQ-010 redirect_valid  in  1  SHALL request a fetch redirect.
REQ-011 redirect_pc  in  64  SHALL be the redirect target.
REQ-012 halt_req  in  1  SHALL indicate that decode has seen a halt instruction.
REQ-013 id_valid  out  1  SHALL indicate that id_inst/id_pc hold an instruction for decode.
REQ-014 id_ready  in  1  SHALL indicate that decode accepts the instruction this cycle.
REQ-015 id_inst  out  64  SHALL be the fetched instruction.
REQ-016 id_pc  out  64  SHALL be the address of id_inst.
REQ-017 halted  out  1  SHALL be the sticky halt status.
REQ-018 err  out  1  SHALL be the sticky error status.
REQ-019 fetch_count  out  64  SHALL count accepted id handshakes.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT, HOLD, HALT and ERR, with a maximum of one outstanding imem request.
REQ-021 IDLE SHALL go to REQ on the next clock; imem_req SHALL be 1 only in REQ, with imem_addr=pc; REQ SHALL go to WAIT unconditionally.
REQ-022 On imem_rvalid=1 in WAIT with kill=0 and imem_err=0, the block SHALL register id_inst=imem_rdata and id_pc=pc, set id_valid=1 and go to HOLD.
REQ-023 HOLD SHALL keep id_valid, id_inst and id_pc stable until id_ready=1; on id_ready=1 it SHALL clear id_valid, set pc=pc+PC_STEP (mod 2^64), increment fetch_count and go to REQ.
REQ-024 On redirect_valid=1 in REQ or WAIT, the block SHALL set pc=redirect_pc and set kill=1 if a response is still pending; a killed response SHALL be discarded (its imem_err ignored), kill SHALL clear, and the FSM SHALL go to REQ.
REQ-025 On redirect_valid=1 in HOLD, the block SHALL drop the buffered instruction (id_valid=0, no count, even if id_ready=1), set pc=redirect_pc and go to REQ.
REQ-026 If redirect_pc[2:0]!=0, the block SHALL go to ERR instead of redirecting.
REQ-027 On imem_rvalid=1 with imem_err=1 and kill=0, the block SHALL set err=1 and go to ERR.
REQ-028 On halt_req=1 in any state except ERR, the block SHALL set halted=1 and id_valid=0 and go to HALT.
REQ-029 Same-cycle priority SHALL be: error > halt > redirect > handshake/response.
REQ-030 HALT and ERR SHALL be terminal until reset, with imem_req=0 and id_valid=0; imem_rvalid SHALL be ignored outside WAIT.
REQ-031 Latency: the first imem_req SHALL occur in the 2nd clock after reset release; for a 1-cycle memory, a sustained fetch SHALL take 3 cycles per instruction when id_ready is held at 1.

Reset
REQ-032 While rst=0, asynchronously: state=IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=0, id_valid=0, id_inst=0, id_pc=0, halted=0, err=0, fetch_count=0.
REQ-033 A reset asserted mid-request SHALL abandon the request; a late response arriving in IDLE or REQ SHALL be ignored.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum, INST_W=64, PC_STEP and the default RESET_PC.
REQ-035 The block SHALL be a single module with no sub-module.

Verification
REQ-036 Reset release, 1-cycle memory, id_ready=1 -> imem_addr sequence 0x1000, 0x1008, 0x1010; id_pc matches; fetch_count=3 after the third handshake.
REQ-037 id_ready=0 for 4 cycles in HOLD -> id_inst/id_pc stable, no imem_req; id_ready=1 -> next imem_addr = id_pc+8.
REQ-038 redirect_pc=0x2000 in WAIT, response arrives next cycle -> response discarded, next imem_addr=0x2000, fetch_count unchanged.
REQ-039 imem_err=1 with rvalid -> err=1, no further imem_req; same-cycle halt_req=1 -> err=1 and halted=0.
REQ-040 redirect_pc=0x2004 -> err=1; halt_req in HOLD with id_ready=1 -> halted=1, fetch_count unchanged.
REQ-041 rst=0 asserted in WAIT, rvalid arrives 1 cycle after release -> ignored; fetch restarts at 0x1000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared state encoding, widths and default fetch parameters for the fetch controller.
package fetch_pkg;

  localparam int INST_W = 64;

  localparam logic [INST_W-1:0] DEFAULT_PC_STEP  = 64'd8;
  localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 64'h1000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT,
    ERR
  } fetch_state_t;

  // Instruction words are 8 bytes, so any target with low bits set cannot be fetched.
  function automatic logic pc_misaligned(input logic [INST_W-1:0] addr);
    return addr[2:0] != 3'b000;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller feeding decode through a one-entry buffer.
// 3 cycles/instruction with a 1-cycle memory; holds the buffered word while id_ready is low.
module fetch_ctrl #(
  parameter logic [fetch_pkg::INST_W-1:0] RESET_PC = fetch_pkg::DEFAULT_RESET_PC,
  parameter logic [fetch_pkg::INST_W-1:0] PC_STEP  = fetch_pkg::DEFAULT_PC_STEP
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req,
  output logic [fetch_pkg::INST_W-1:0]  imem_addr,
  input  logic                          imem_rvalid,
  input  logic [fetch_pkg::INST_W-1:0]  imem_rdata,
  input  logic                          imem_err,
  input  logic                          redirect_valid,
  input  logic [fetch_pkg::INST_W-1:0]  redirect_pc,
  input  logic                          halt_req,
  output logic                          id_valid,
  input  logic                          id_ready,
  output logic [fetch_pkg::INST_W-1:0]  id_inst,
  output logic [fetch_pkg::INST_W-1:0]  id_pc,
  output logic                          halted,
  output logic                          err,
  output logic [fetch_pkg::INST_W-1:0]  fetch_count
);
  import fetch_pkg::*;

  fetch_state_t      state, state_nxt;
  logic [INST_W-1:0] pc;
  logic              kill, kill_nxt;

  logic resp, resp_live, redir_state, redir_bad;
  logic go_err, go_halt, do_redirect, load_resp, accept;

  assign resp        = (state == WAIT) && imem_rvalid;
  assign resp_live   = resp && !kill;
  assign redir_state = (state == REQ) || (state == WAIT) || (state == HOLD);
  assign redir_bad   = redir_state && redirect_valid && pc_misaligned(redirect_pc);

  assign imem_req  = (state == REQ);
  assign imem_addr = (state == REQ) ? pc : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    kill_nxt    = kill;
    go_err      = 1'b0;
    go_halt     = 1'b0;
    do_redirect = 1'b0;
    load_resp   = 1'b0;
    accept      = 1'b0;

    if (state == ERR || state == HALT) begin
      state_nxt = state;
    end else if ((resp_live && imem_err) || redir_bad) begin
      go_err    = 1'b1;
      kill_nxt  = 1'b0;
      state_nxt = ERR;
    end else if (halt_req) begin
      go_halt   = 1'b1;
      kill_nxt  = 1'b0;
      state_nxt = HALT;
    end else if (redir_state && redirect_valid) begin
      do_redirect = 1'b1;
      // A request issued this cycle or still unanswered will return later; absorb it in WAIT.
      if (state == REQ || (state == WAIT && !imem_rvalid)) begin
        kill_nxt  = 1'b1;
        state_nxt = WAIT;
      end else begin
        kill_nxt  = 1'b0;
        state_nxt = REQ;
      end
    end else begin
      case (state)
        IDLE: state_nxt = REQ;
        REQ:  state_nxt = WAIT;
        WAIT: begin
          if (resp) begin
            if (kill) begin
              kill_nxt  = 1'b0;
              state_nxt = REQ;
            end else begin
              load_resp = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (id_ready) begin
            accept    = 1'b1;
            state_nxt = REQ;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      kill        <= 1'b0;
      id_valid    <= 1'b0;
      id_inst     <= '0;
      id_pc       <= '0;
      halted      <= 1'b0;
      err         <= 1'b0;
      fetch_count <= '0;
    end else begin
      kill <= kill_nxt;

      if (do_redirect) begin
        pc <= redirect_pc;
      end else if (accept) begin
        pc <= pc + PC_STEP;
      end

      if (load_resp) begin
        id_valid <= 1'b1;
        id_inst  <= imem_rdata;
        id_pc    <= pc;
      end else if (accept || do_redirect || go_halt || go_err) begin
        id_valid <= 1'b0;
      end

      if (go_halt) halted <= 1'b1;
      if (go_err)  err    <= 1'b1;
      if (accept)  fetch_count <= fetch_count + 64'd1;
    end
  end

endmodule
